// File: rtl/fuzz_seq_if.sv
// fuzz_seq bus bundle: start/crisp inputs, parameter-bank write port,
// shared trapezoid-evaluator operands/result, and registered memberships.
interface fuzz_seq_if;
  logic               start;
  logic signed [7:0]  x0;
  logic signed [7:0]  x1;

  logic               cfg_we;
  logic        [4:0]  cfg_addr;
  logic signed [7:0]  cfg_data;

  logic signed [7:0]  tz_x;
  logic signed [7:0]  tz_a;
  logic signed [7:0]  tz_b;
  logic signed [7:0]  tz_c;
  logic signed [7:0]  tz_d;
  logic        [15:0] tz_mu;

  logic        [15:0] mu_neg0;
  logic        [15:0] mu_zero0;
  logic        [15:0] mu_pos0;
  logic        [15:0] mu_neg1;
  logic        [15:0] mu_zero1;
  logic        [15:0] mu_pos1;

  logic               busy;
  logic               done;
  logic               cfg_err;

  // Sequencer side
  modport slave (
    input  start, x0, x1, cfg_we, cfg_addr, cfg_data, tz_mu,
    output tz_x, tz_a, tz_b, tz_c, tz_d,
           mu_neg0, mu_zero0, mu_pos0, mu_neg1, mu_zero1, mu_pos1,
           busy, done, cfg_err
  );

  // Controller / evaluator side
  modport master (
    output start, x0, x1, cfg_we, cfg_addr, cfg_data, tz_mu,
    input  tz_x, tz_a, tz_b, tz_c, tz_d,
           mu_neg0, mu_zero0, mu_pos0, mu_neg1, mu_zero1, mu_pos1,
           busy, done, cfg_err
  );
endinterface

// File: rtl/fuzz_seq.sv
// fuzz_seq: fuzzifier sequencer. Walks six membership slots (neg/zero/pos
// for each of two inputs) through one shared trapezoid evaluator, one slot
// per cycle, and registers each result.
//
// state | meaning
// IDLE  | waiting for start; operands show slot 0; bank writable
// EVAL  | slot k on the evaluator; result captured each edge, k advances
// DONE  | one-cycle completion pulse, then back to IDLE
module fuzz_seq #(
  parameter bit RST_DEFAULTS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  fuzz_seq_if.slave  io
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Reset-time default trapezoid table, same for both inputs.
  function automatic logic signed [7:0] dflt(input int a);
    int s;
    int p;
    s = (a / 4) % 3;
    p = a % 4;
    dflt = 8'sd0;
    case (s)
      0: case (p)
           0, 1:    dflt = -8'sd128;
           2:       dflt = -8'sd64;
           default: dflt = 8'sd0;
         endcase
      1: case (p)
           0:       dflt = -8'sd64;
           3:       dflt = 8'sd64;
           default: dflt = 8'sd0;
         endcase
      default: case (p)
           0:       dflt = 8'sd0;
           1:       dflt = 8'sd64;
           default: dflt = 8'sd127;
         endcase
    endcase
  endfunction

  logic [1:0]        state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic signed [7:0] xr0_q, xr1_q;
  logic signed [7:0] bank_q [24];
  logic [15:0]       mu_q [6];
  logic              cfg_err_q;
  // A write accepted together with start is parked here and committed at
  // the end of the pass so the pass in flight keeps the old operands.
  logic              pend_q;
  logic [4:0]        pend_addr_q;
  logic signed [7:0] pend_data_q;

  logic       busy;
  logic       start_acc;
  logic       cfg_ok;
  logic [2:0] slot;
  logic [4:0] base;

  assign busy      = (state_q != IDLE);
  assign start_acc = (state_q == IDLE) && io.start;
  assign cfg_ok    = io.cfg_we && !busy && (io.cfg_addr < 5'd24);
  assign slot      = (state_q == EVAL) ? k_q : 3'd0;
  assign base      = {slot, 2'b00};

  // Operand mux onto the shared evaluator.
  assign io.tz_x = ((state_q == EVAL) && (k_q >= 3'd3)) ? xr1_q : xr0_q;
  assign io.tz_a = bank_q[base];
  assign io.tz_b = bank_q[base + 5'd1];
  assign io.tz_c = bank_q[base + 5'd2];
  assign io.tz_d = bank_q[base + 5'd3];

  assign io.mu_neg0  = mu_q[0];
  assign io.mu_zero0 = mu_q[1];
  assign io.mu_pos0  = mu_q[2];
  assign io.mu_neg1  = mu_q[3];
  assign io.mu_zero1 = mu_q[4];
  assign io.mu_pos1  = mu_q[5];
  assign io.busy     = busy;
  assign io.done     = (state_q == DONE);
  assign io.cfg_err  = cfg_err_q;

  // Next state and slot index.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: if (io.start) begin
        state_d = EVAL;
        k_d     = 3'd0;
      end
      EVAL: begin
        k_d = k_q + 3'd1;
        if (k_q == 3'd5) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, input capture, membership capture and parameter bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= 3'd0;
      xr0_q       <= 8'sd0;
      xr1_q       <= 8'sd0;
      cfg_err_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= 5'd0;
      pend_data_q <= 8'sd0;
      for (int i = 0; i < 6; i++) mu_q[i] <= 16'd0;
      for (int i = 0; i < 24; i++) bank_q[i] <= RST_DEFAULTS ? dflt(i) : 8'sd0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cfg_err_q <= io.cfg_we && !cfg_ok;
      if (start_acc) begin
        xr0_q <= io.x0;
        xr1_q <= io.x1;
      end
      if (state_q == EVAL) mu_q[k_q] <= io.tz_mu;
      if (cfg_ok) begin
        if (io.start) begin
          pend_q      <= 1'b1;
          pend_addr_q <= io.cfg_addr;
          pend_data_q <= io.cfg_data;
        end else begin
          bank_q[io.cfg_addr] <= io.cfg_data;
        end
      end
      if ((state_q == DONE) && pend_q) begin
        bank_q[pend_addr_q] <= pend_data_q;
        pend_q              <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fuzz_seq.sv
// Self-checking bench for fuzz_seq: vector table of full passes, hand-written
// corner sequences, and a randomized run against a timeline-level model.
module tb_fuzz_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a, rst_z;
  logic              start;
  logic signed [7:0] x0, x1, cfg_data;
  logic              cfg_we;
  logic [4:0]        cfg_addr;

  fuzz_seq_if ia();
  fuzz_seq_if iz();

  assign ia.start = start;    assign iz.start = start;
  assign ia.x0 = x0;          assign iz.x0 = x0;
  assign ia.x1 = x1;          assign iz.x1 = x1;
  assign ia.cfg_we = cfg_we;  assign iz.cfg_we = cfg_we;
  assign ia.cfg_addr = cfg_addr; assign iz.cfg_addr = cfg_addr;
  assign ia.cfg_data = cfg_data; assign iz.cfg_data = cfg_data;
  // Evaluator stand-in: mu = {x, a}
  assign ia.tz_mu = {ia.tz_x, ia.tz_a};
  assign iz.tz_mu = {iz.tz_x, iz.tz_a};

  fuzz_seq #(.RST_DEFAULTS(1'b1)) u_def  (.clk(clk), .rst(rst_a), .io(ia));
  fuzz_seq #(.RST_DEFAULTS(1'b0)) u_zero (.clk(clk), .rst(rst_z), .io(iz));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; cfg_we = 1'b0; cfg_addr = 5'd0; cfg_data = 8'sd0;
  endtask

  function automatic logic [15:0] mu_a(input int s);
    case (s)
      0: mu_a = ia.mu_neg0;  1: mu_a = ia.mu_zero0; 2: mu_a = ia.mu_pos0;
      3: mu_a = ia.mu_neg1;  4: mu_a = ia.mu_zero1; default: mu_a = ia.mu_pos1;
    endcase
  endfunction

  function automatic logic [15:0] mu_z(input int s);
    case (s)
      0: mu_z = iz.mu_neg0;  1: mu_z = iz.mu_zero0; 2: mu_z = iz.mu_pos0;
      3: mu_z = iz.mu_neg1;  4: mu_z = iz.mu_zero1; default: mu_z = iz.mu_pos1;
    endcase
  endfunction

  task automatic cfg_write(input logic [4:0] a, input logic signed [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // Start a pass and wait until the FSM is back in IDLE.
  task automatic do_pass(input logic signed [7:0] a0, input logic signed [7:0] a1);
    start = 1'b1; x0 = a0; x1 = a1;
    tick();
    start = 1'b0;
    repeat (7) tick();
  endtask

  typedef struct {
    logic signed [7:0]  x0;
    logic signed [7:0]  x1;
    logic [5:0][15:0]   mu;
  } pass_vec_t;

  pass_vec_t vecs [4];

  logic signed [7:0] trap [3][4];
  logic signed [7:0] mbank [24];
  logic signed [7:0] sbank [24];
  logic [15:0]       mmu [6];
  logic signed [7:0] xhist [64];

  initial begin
    int busy_cnt, done_cnt, done_at, last_done, n_done;
    logic signed [7:0] sx0, sx1, xs;
    logic exp_err, bsy;
    int e0, k;

    vecs[0].x0 = 8'sd10;   vecs[0].x1 = -8'sd20;
    vecs[0].mu = {16'hEC00, 16'hECC0, 16'hEC80, 16'h0A00, 16'h0AC0, 16'h0A80};
    vecs[1].x0 = -8'sd128; vecs[1].x1 = 8'sd127;
    vecs[1].mu = {16'h7F00, 16'h7FC0, 16'h7F80, 16'h8000, 16'h80C0, 16'h8080};
    vecs[2].x0 = 8'sd0;    vecs[2].x1 = 8'sd0;
    vecs[2].mu = {16'h0000, 16'h00C0, 16'h0080, 16'h0000, 16'h00C0, 16'h0080};
    vecs[3].x0 = 8'sd127;  vecs[3].x1 = -8'sd1;
    vecs[3].mu = {16'hFF00, 16'hFFC0, 16'hFF80, 16'h7F00, 16'h7FC0, 16'h7F80};

    trap[0][0] = -8'sd128; trap[0][1] = -8'sd128; trap[0][2] = -8'sd64; trap[0][3] = 8'sd0;
    trap[1][0] = -8'sd64;  trap[1][1] = 8'sd0;    trap[1][2] = 8'sd0;   trap[1][3] = 8'sd64;
    trap[2][0] = 8'sd0;    trap[2][1] = 8'sd64;   trap[2][2] = 8'sd127; trap[2][3] = 8'sd127;

    // Reset state
    idle_inputs(); x0 = 8'sd0; x1 = 8'sd0;
    rst_a = 1'b1; rst_z = 1'b1;
    tick(); tick();
    check("rst_busy", 32'(ia.busy), 32'd0);
    check("rst_done", 32'(ia.done), 32'd0);
    check("rst_cfg_err", 32'(ia.cfg_err), 32'd0);
    for (int s = 0; s < 6; s++) check($sformatf("rst_mu%0d", s), 32'(mu_a(s)), 32'd0);
    check("rst_tz_a_def", {24'd0, ia.tz_a}, 32'h80);
    check("rst_tz_c_def", {24'd0, ia.tz_c}, 32'hC0);
    check("rst_tz_a_zero", {24'd0, iz.tz_a}, 32'h00);
    check("rst_tz_x", {24'd0, ia.tz_x}, 32'h00);
    rst_a = 1'b0; rst_z = 1'b0;

    // Vector table: one pass per record, timing and slots checked per edge
    for (int v = 0; v < 4; v++) begin
      start = 1'b1; x0 = vecs[v].x0; x1 = vecs[v].x1;
      tick();
      start = 1'b0; x0 = 8'sh55; x1 = 8'sh33;
      busy_cnt = ia.busy ? 1 : 0;
      done_cnt = ia.done ? 1 : 0;
      done_at = -1;
      for (int c = 1; c <= 7; c++) begin
        tick();
        if (c <= 6) check($sformatf("vec%0d_slot%0d", v, c - 1), 32'(mu_a(c - 1)), 32'(vecs[v].mu[c - 1]));
        if (ia.busy) busy_cnt++;
        if (ia.done) begin done_cnt++; done_at = c; end
      end
      check($sformatf("vec%0d_busy_cycles", v), 32'(busy_cnt), 32'd7);
      check($sformatf("vec%0d_done_count", v), 32'(done_cnt), 32'd1);
      check($sformatf("vec%0d_done_cycle", v), 32'(done_at), 32'd6);
    end

    // Write zero0.a = -32, then a pass sees it
    cfg_write(5'd4, -8'sd32);
    check("wr4_cfg_err", 32'(ia.cfg_err), 32'd0);
    do_pass(8'sd10, -8'sd20);
    check("wr4_slot1", 32'(mu_a(1)), 32'h0AE0);
    check("wr4_slot0", 32'(mu_a(0)), 32'h0A80);

    // Out-of-range write: error pulse, bank untouched
    cfg_write(5'd24, 8'sh7F);
    check("bad_addr_err", 32'(ia.cfg_err), 32'd1);
    tick();
    check("bad_addr_err_clr", 32'(ia.cfg_err), 32'd0);
    do_pass(8'sd10, -8'sd20);
    check("bad_addr_slot0", 32'(mu_a(0)), 32'h0A80);
    check("bad_addr_slot1", 32'(mu_a(1)), 32'h0AE0);
    check("bad_addr_slot3", 32'(mu_a(3)), 32'hEC80);
    cfg_write(5'd4, -8'sd64);

    // Write together with start: current pass keeps old value
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 8'sh10;
    start = 1'b1; x0 = 8'sd5; x1 = 8'sd6;
    tick();
    idle_inputs();
    repeat (7) tick();
    check("same_cyc_old", 32'(mu_a(0)), 32'h0580);
    check("same_cyc_err", 32'(ia.cfg_err), 32'd0);
    do_pass(8'sd5, 8'sd6);
    check("same_cyc_new", 32'(mu_a(0)), 32'h0510);
    cfg_write(5'd0, -8'sd128);

    // Write and start during a pass
    start = 1'b1; x0 = 8'sd3; x1 = 8'sd4;
    tick();
    start = 1'b0;
    tick();
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 8'sh11; start = 1'b1;
    tick();
    cfg_we = 1'b0;
    check("busy_wr_err", 32'(ia.cfg_err), 32'd1);
    done_cnt = ia.done ? 1 : 0;
    tick();
    check("busy_wr_err_clr", 32'(ia.cfg_err), 32'd0);
    if (ia.done) done_cnt++;
    for (int c = 4; c <= 16; c++) begin
      if (c == 6) start = 1'b0;
      tick();
      if (ia.done) done_cnt++;
    end
    check("busy_start_done_count", 32'(done_cnt), 32'd1);
    check("busy_start_slot0", 32'(mu_a(0)), 32'h0380);
    do_pass(8'sd3, 8'sd4);
    check("busy_wr_bank0", 32'(mu_a(0)), 32'h0380);

    // Mid-pass reset on both instances
    cfg_write(5'd0, 8'sh33);
    start = 1'b1; x0 = 8'sd9; x1 = 8'sd2;
    tick();
    start = 1'b0;
    tick(); tick();
    rst_a = 1'b1; rst_z = 1'b1;
    tick();
    rst_a = 1'b0; rst_z = 1'b0;
    check("midrst_busy", 32'(ia.busy), 32'd0);
    check("midrst_done", 32'(ia.done), 32'd0);
    for (int s = 0; s < 6; s++) begin
      check($sformatf("midrst_mu%0d", s), 32'(mu_a(s)), 32'd0);
      check($sformatf("midrst_z_mu%0d", s), 32'(mu_z(s)), 32'd0);
    end
    check("midrst_bank0_def", {24'd0, ia.tz_a}, 32'h80);
    check("midrst_bank0_zero", {24'd0, iz.tz_a}, 32'h00);
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ia.done || iz.done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    do_pass(8'sd9, 8'sd2);
    check("after_rst_def_slot0", 32'(mu_a(0)), 32'h0980);
    check("after_rst_zero_slot0", 32'(mu_z(0)), 32'h0900);
    check("after_rst_zero_slot5", 32'(mu_z(5)), 32'h0200);

    // start held high: a pass every 8 cycles, x0 resampled each time
    start = 1'b1;
    last_done = -1;
    n_done = 0;
    for (int t = 0; t < 40; t++) begin
      x0 = 8'(t * 7 + 1);
      x1 = 8'(t);
      xhist[t] = x0;
      tick();
      if (ia.done) begin
        n_done++;
        if (t >= 6) check($sformatf("held_x0_t%0d", t), 32'(mu_a(0)), 32'({xhist[t - 6], 8'h80}));
        if (last_done >= 0) check($sformatf("held_period_t%0d", t), 32'(t - last_done), 32'd8);
        last_done = t;
      end
    end
    check("held_done_count", 32'(n_done), 32'd5);
    start = 1'b0;
    repeat (8) tick();

    // Randomized run against a timeline model
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    for (int a = 0; a < 24; a++) mbank[a] = trap[(a / 4) % 3][a % 4];
    for (int s = 0; s < 6; s++) mmu[s] = 16'd0;
    sbank = mbank; sx0 = 8'sd0; sx1 = 8'sd0;
    e0 = -100;
    for (int n = 1; n <= 400; n++) begin
      start    = ($urandom_range(0, 2) == 0);
      x0       = 8'($urandom);
      x1       = 8'($urandom);
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_addr = 5'($urandom_range(0, 31));
      cfg_data = 8'($urandom);
      bsy = ((n - 1 - e0) >= 0) && ((n - 1 - e0) <= 6);
      k = n - e0 - 1;
      if (k >= 0 && k <= 5) begin
        xs = (k < 3) ? sx0 : sx1;
        mmu[k] = {xs, sbank[4 * k]};
      end
      exp_err = cfg_we && (bsy || cfg_addr >= 5'd24);
      if (!bsy && start) begin
        e0 = n; sbank = mbank; sx0 = x0; sx1 = x1;
      end
      if (cfg_we && !bsy && cfg_addr < 5'd24) mbank[cfg_addr] = cfg_data;
      tick();
      check($sformatf("rnd%0d_busy", n), 32'(ia.busy), 32'(((n - e0) >= 0) && ((n - e0) <= 6)));
      check($sformatf("rnd%0d_done", n), 32'(ia.done), 32'((n - e0) == 6));
      check($sformatf("rnd%0d_cfg_err", n), 32'(ia.cfg_err), 32'(exp_err));
      for (int s = 0; s < 6; s++) check($sformatf("rnd%0d_mu%0d", n, s), 32'(mu_a(s)), 32'(mmu[s]));
    end
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fuzz_seq.md
FUZZ_SEQ -- requirements
Module: fuzz_seq

Interface
REQ-001 Parameter RST_DEFAULTS, default 1, meaning: 1 = parameter bank loads the default table of REQ-016 at reset; 0 = all entries clear to 0.
REQ-002 Reset is synchronous and active-high; single clock domain.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  request one evaluation pass over both inputs.
REQ-006 x0, x1  in  8 signed  crisp inputs, sampled only when start is accepted.
REQ-007 cfg_we, cfg_addr[4:0], cfg_data[7:0] signed  in  parameter-bank write port.
REQ-008 tz_x, tz_a, tz_b, tz_c, tz_d  out  8 signed each  operands to the single shared trapezoid evaluator.
REQ-009 tz_mu  in  16  combinational membership result from the shared evaluator.
REQ-010 mu_neg0, mu_zero0, mu_pos0, mu_neg1, mu_zero1, mu_pos1  out  16 each  registered memberships (digit = input index).
REQ-011 busy  out  1 | done  out  1 | cfg_err  out  1.

Function
REQ-012 The FSM SHALL have states IDLE, EVAL, DONE; reset enters IDLE.
REQ-013 IDLE: start=1 SHALL latch x0/x1 into xr0/xr1, clear the 3-bit index k to 0, and enter EVAL on the next edge.
REQ-014 EVAL: tz_x SHALL equal xr0 for k<3 and xr1 for k>=3; tz_a..tz_d SHALL equal the bank entries for slot k; at each edge, tz_mu SHALL be written to output slot k and k SHALL increment.
REQ-015 Slot order: k=0 neg0, 1 zero0, 2 pos0, 3 neg1, 4 zero1, 5 pos1. Bank address = 4*k + p, with p = 0 a, 1 b, 2 c, 3 d; addresses 0..23 are valid.
REQ-016 Default bank, identical for both inputs: neg (-128,-128,-64,0); zero (-64,0,0,64); pos (0,64,127,127).
REQ-017 After slot 5 is captured, the FSM SHALL enter DONE for exactly one cycle with done=1, then return to IDLE.
REQ-018 Latency: start accepted at edge E0 -> mu slot k written at edge E0+1+k -> done high in the cycle after E0+6 -> IDLE after E0+7; 8 cycles start-to-start minimum.
REQ-019 busy SHALL be 1 in EVAL and DONE and 0 in IDLE; start SHALL be ignored while busy=1, with no queuing.
REQ-020 In IDLE and DONE, tz_* SHALL be driven with slot-0 operands and tz_x=xr0; tz_mu SHALL be ignored in those states.
REQ-021 mu outputs SHALL hold their value until overwritten; a pass updates all six slots.
REQ-022 A config write with cfg_we=1, busy=0, and cfg_addr<24 SHALL update the entry at the edge; the new value SHALL be visible to a start accepted in the same cycle only from the next pass.
REQ-023 cfg_we=1 with busy=1 or cfg_addr>=24 SHALL leave the bank unchanged and SHALL assert cfg_err for one cycle, registered at the next edge; otherwise cfg_err=0.
REQ-024 start and cfg_we in the same IDLE cycle: both SHALL take effect, with the write following REQ-022.
REQ-025 The block performs no arithmetic on tz_mu; values pass through at full 16-bit width, unmodified.

Reset
REQ-026 rst=1 SHALL force IDLE, k=0, xr0=xr1=0, all mu outputs 0, busy=0, done=0, cfg_err=0, and the bank per RST_DEFAULTS, including mid-pass; no partial results survive.
REQ-027 rst SHALL take priority over start and cfg_we in the same cycle.

Verification
REQ-028 Bench models tz_mu = {tz_x, tz_a} (concatenation). Test: x0=10, x1=-20, start for 1 cycle -> edges 1..6 write slots 0x0A80, 0x0AC0, 0x0A00, 0xEC80, 0xECC0, 0xEC00; done pulses once in cycle 7; busy is high for 7 cycles.
REQ-029 Write addr 4 (zero0.a) = -32 in IDLE, then start -> slot 1 = 0x0AE0 with x0=10; write addr 24 -> cfg_err pulses and the bank is unchanged.
REQ-030 cfg_we during EVAL at addr 0 -> cfg_err=1 for one cycle, bank[0] stays -128; start pulses during busy -> no extra pass, done pulses once.
REQ-031 Assert rst at edge E0+3 of a pass -> next cycle: IDLE, all mu=0, done never asserted; with RST_DEFAULTS=0 the bank reads all 0 (slot 0 = {x0, 0x00}).
REQ-032 start held high continuously -> passes start every 8 cycles, done pulses every 8 cycles, and x0 is resampled each pass.
